nano_mem_arbiter: RTL
=====================

Name: nano_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the nano_rv32i instruction-fetch port and data port.
- Replaces the split i_memory/d_memory arrangement with a unified memory of the same style: reads return data one cycle after the read strobe, and writes commit at the clock edge.
- Data accesses win by default. A bounded-starvation counter guarantees forward progress for fetch.
- Read data is routed back to the requester that issued the read.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced through (legal range 1..15)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n_i  input  1  asynchronous active-low reset
i_addr_i  input  ADDR_W  fetch address
i_rd_i  input  1  fetch read request, held until i_gnt_o
i_gnt_o  output  1  fetch request accepted this cycle
i_rvalid_o  output  1  i_data_o valid
i_data_o  output  DATA_W  fetch read data
d_addr_i  input  ADDR_W  data address
d_rd_i  input  1  data read request, held until d_gnt_o
d_wr_i  input  1  data write request, held until d_gnt_o
d_data_i  input  DATA_W  write data
d_gnt_o  output  1  data request accepted this cycle
d_rvalid_o  output  1  d_data_o valid
d_data_o  output  DATA_W  data read data
m_addr_o  output  ADDR_W  memory address
m_rd_o  output  1  memory read strobe
m_wr_o  output  1  memory write strobe
m_data_o  output  DATA_W  memory write data
m_data_i  input  DATA_W  memory read data, valid the cycle after m_rd_o

Behaviour:
- Clock is clk_i. Reset is rst_n_i: asynchronous, active-low.
- While rst_n_i=0, all of the following are forced to 0 asynchronously:
  - i_gnt_o, d_gnt_o, m_rd_o, m_wr_o, i_rvalid_o, d_rvalid_o
  - starve counter, response tracker
- Grant and command path are combinational in the same cycle:
  - d_req = d_rd_i | d_wr_i.
  - sel_i = i_rd_i & (!d_req | starve_cnt == STARVE_MAX).
  - sel_d = d_req & !sel_i.
  - i_gnt_o = sel_i; d_gnt_o = sel_d. At most one grant per cycle.
- Memory command:
  - sel_i: m_addr_o=i_addr_i, m_rd_o=1, m_wr_o=0.
  - sel_d with d_wr_i=1: m_addr_o=d_addr_i, m_wr_o=1, m_rd_o=0.
  - sel_d read: m_addr_o=d_addr_i, m_rd_o=1.
  - Idle: m_rd_o=m_wr_o=0, m_addr_o=i_addr_i.
  - m_data_o = d_data_i always.
- d_rd_i and d_wr_i both high: treated as a write only, and no d_rvalid_o follows.
- Starve counter: 4-bit, saturating at STARVE_MAX.
  - Increments on a cycle with sel_d=1 and i_rd_i=1.
  - Clears on sel_i=1 or i_rd_i=0.
  - Otherwise holds.
- Response tracker FSM, registered:
  - States: IDLE, RESP_I, RESP_D.
  - Next state: RESP_I if sel_i, RESP_D if sel_d and it is a read, else IDLE.
  - Any state may transition to any state each cycle. This allows fully pipelined back-to-back reads with one access per cycle.
- Response outputs:
  - i_rvalid_o = (state==RESP_I); d_rvalid_o = (state==RESP_D). Each pulse lasts exactly 1 cycle per granted read.
  - i_data_o = d_data_o = m_data_i combinationally; qualified only by the corresponding rvalid.
  - Read latency: grant in cycle N gives rvalid and data in cycle N+1.
- Writes complete at the grant edge and produce no response.
- Requesters must keep address/data/strobes stable until granted. A request deasserted before grant is dropped silently.
- Reset mid-operation: any in-flight response is discarded and no rvalid is emitted after reset release. The first grant is possible in the first cycle with rst_n_i=1.
- Addresses and data pass unmodified; no alignment or width conversion.

Test Plan:
1. Fetch-only stream at 0x0, 0x4, 0x8 with memory holding 0x00000013, 0x00100093, 0x00200113 -> i_gnt_o=1 on three consecutive cycles; i_rvalid_o on the following three cycles with those words in order.
2. i_rd_i and d_rd_i asserted together, d_addr_i=0x100 holding 0xCAFEF00D -> d_gnt_o=1, i_gnt_o=0, m_addr_o=0x100; next cycle d_rvalid_o=1, d_data_o=0xCAFEF00D; i_gnt_o=1 in that same cycle.
3. d_rd_i held high continuously with i_rd_i pending, STARVE_MAX=4 -> d_gnt_o on 4 cycles, i_gnt_o on the 5th, d_gnt_o resumes on the 6th with counter back at 0.
4. Data write 0xDEADBEEF to 0x40, then data read 0x40 -> m_wr_o=1 for one cycle with no d_rvalid_o; read returns 0xDEADBEEF one cycle after its grant.
5. d_rd_i=d_wr_i=1, d_addr_i=0x80, d_data_i=0x12345678 -> m_wr_o=1, m_rd_o=0, no d_rvalid_o; subsequent read of 0x80 returns 0x12345678.
6. rst_n_i driven low in the cycle after a fetch grant -> i_rvalid_o stays 0; all grants and strobes read 0 immediately, without waiting for a clock edge; normal grant in the first cycle after release.

Source files
------------

// File: rtl/nano_mem_arbiter_if.sv
// Bus bundle between the nano_rv32i fetch/data requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface nano_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_rd_i;
    logic              i_gnt_o;
    logic              i_rvalid_o;
    logic [DATA_W-1:0] i_data_o;
    logic [ADDR_W-1:0] d_addr_i;
    logic              d_rd_i;
    logic              d_wr_i;
    logic [DATA_W-1:0] d_data_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_data_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic              m_rd_o;
    logic              m_wr_o;
    logic [DATA_W-1:0] m_data_o;
    logic [DATA_W-1:0] m_data_i;

    modport slave (
        input  i_addr_i, i_rd_i, d_addr_i, d_rd_i, d_wr_i, d_data_i, m_data_i,
        output i_gnt_o, i_rvalid_o, i_data_o, d_gnt_o, d_rvalid_o, d_data_o,
               m_addr_o, m_rd_o, m_wr_o, m_data_o
    );

    modport master (
        output i_addr_i, i_rd_i, d_addr_i, d_rd_i, d_wr_i, d_data_i, m_data_i,
        input  i_gnt_o, i_rvalid_o, i_data_o, d_gnt_o, d_rvalid_o, d_data_o,
               m_addr_o, m_rd_o, m_wr_o, m_data_o
    );
endinterface

// File: rtl/nano_mem_arbiter.sv
// Single-port memory arbiter for nano_rv32i: data port wins by default, fetch is forced
// through after STARVE_MAX consecutive data grants; read responses are steered back one cycle later.
module nano_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    nano_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic        d_req_s;
    logic        sel_i_s;
    logic        sel_d_s;
    logic        d_read_s;
    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_cnt_nxt_s;
    resp_state_e state_r;
    resp_state_e state_nxt_s;

    // Arbitration: data wins unless a fetch has waited STARVE_MAX data grants.
    always_comb begin
        d_req_s  = bus.d_rd_i | bus.d_wr_i;
        sel_i_s  = bus.i_rd_i & (~d_req_s | (starve_cnt_r == STARVE_LIM));
        sel_d_s  = d_req_s & ~sel_i_s;
        // A simultaneous rd+wr is a plain write, so it never expects a response.
        d_read_s = sel_d_s & ~bus.d_wr_i;
    end

    // Grants and memory strobes; the reset term drops them without waiting for a clock edge.
    always_comb begin
        bus.i_gnt_o  = 1'b0;
        bus.d_gnt_o  = 1'b0;
        bus.m_rd_o   = 1'b0;
        bus.m_wr_o   = 1'b0;
        bus.m_addr_o = bus.i_addr_i;
        if (sel_d_s) begin
            bus.m_addr_o = bus.d_addr_i;
        end else begin
            bus.m_addr_o = bus.i_addr_i;
        end
        if (!rst_n_i) begin
            bus.i_gnt_o = 1'b0;
            bus.d_gnt_o = 1'b0;
        end else if (sel_i_s) begin
            bus.i_gnt_o = 1'b1;
            bus.m_rd_o  = 1'b1;
        end else if (sel_d_s) begin
            bus.d_gnt_o = 1'b1;
            bus.m_wr_o  = bus.d_wr_i;
            bus.m_rd_o  = ~bus.d_wr_i;
        end else begin
            bus.m_rd_o  = 1'b0;
            bus.m_wr_o  = 1'b0;
        end
        bus.m_data_o = bus.d_data_i;
    end

    // Starvation counter and response-tracker next state.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        state_nxt_s      = IDLE;
        if (sel_i_s || !bus.i_rd_i) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (sel_d_s && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
        if (sel_i_s) begin
            state_nxt_s = RESP_I;
        end else if (d_read_s) begin
            state_nxt_s = RESP_D;
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // State registers; reset discards any in-flight response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= IDLE;
            starve_cnt_r <= 4'd0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Response steering: memory data goes to both ports, qualified by the owner's rvalid.
    always_comb begin
        bus.i_rvalid_o = 1'b0;
        bus.d_rvalid_o = 1'b0;
        case (state_r)
            RESP_I:  bus.i_rvalid_o = 1'b1;
            RESP_D:  bus.d_rvalid_o = 1'b1;
            IDLE:    bus.i_rvalid_o = 1'b0;
            default: bus.d_rvalid_o = 1'b0;
        endcase
        bus.i_data_o = bus.m_data_i;
        bus.d_data_o = bus.m_data_i;
    end

endmodule
